// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW/WAW hazard detection with a per-register
// latency scoreboard, operand forwarding select and a stall performance counter.
module hazard_scoreboard #(
    parameter int NUM_FWD = 2,
    parameter int MAX_LAT = 7,
    localparam int CW = $clog2(MAX_LAT + 1),
    localparam int FW = $clog2(NUM_FWD + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_id_valid,
    input  logic [6:0]           i_id_opcode,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic [4:0]           i_id_rd,
    input  logic [CW-1:0]        i_id_lat,
    input  logic                 i_flush,
    input  logic [NUM_FWD-1:0]   i_fwd_valid,
    input  logic [5*NUM_FWD-1:0] i_fwd_rd,
    output logic [FW-1:0]        o_forward_a,
    output logic [FW-1:0]        o_forward_b,
    output logic                 o_stall,
    output logic [31:0]          o_busy,
    output logic [31:0]          o_stall_cycles
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [CW-1:0] LAT_CAP = CW'(MAX_LAT);

    // Entry 0 is kept at zero so x0 reads as never pending.
    logic [CW-1:0] r_cnt [32];
    logic [31:0]   r_stall_cycles;

    logic          w_rs1_used;
    logic          w_rs2_used;
    logic          w_raw1;
    logic          w_raw2;
    logic          w_waw;
    logic          w_stall;
    logic          w_issue;
    logic [CW-1:0] w_load;
    logic [FW-1:0] w_fwd_a;
    logic [FW-1:0] w_fwd_b;

    // Operand usage decode; x0 is folded in as "not used".
    always_comb begin
        w_rs1_used = !((i_id_opcode == OP_JAL) || (i_id_opcode == OP_LUI) ||
                       (i_id_opcode == OP_AUIPC)) && (i_id_rs1 != 5'd0);
        w_rs2_used = ((i_id_opcode == OP_R) || (i_id_opcode == OP_STORE) ||
                      (i_id_opcode == OP_BRANCH)) && (i_id_rs2 != 5'd0);
    end

    // Forwarding select: scan from oldest to youngest so the youngest match wins.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && (i_fwd_rd[5*k +: 5] == i_id_rs1) && w_rs1_used)
                w_fwd_a = FW'(k + 1);
            if (i_fwd_valid[k] && (i_fwd_rd[5*k +: 5] == i_id_rs2) && w_rs2_used)
                w_fwd_b = FW'(k + 1);
        end
    end

    // Hazard detection, stall and issue qualification.
    always_comb begin
        w_raw1  = w_rs1_used && (r_cnt[i_id_rs1] != '0);
        w_raw2  = w_rs2_used && (r_cnt[i_id_rs2] != '0);
        w_waw   = (i_id_lat != '0) && (i_id_rd != 5'd0) && (r_cnt[i_id_rd] > i_id_lat);
        w_stall = !i_rst && i_id_valid && !i_flush && (w_raw1 || w_raw2 || w_waw);
        w_issue = i_id_valid && !i_flush && !w_stall &&
                  (i_id_lat != '0) && (i_id_rd != 5'd0);
        w_load  = (i_id_lat > LAT_CAP) ? LAT_CAP : i_id_lat;
    end

    // Scoreboard counters: load on issue, otherwise count down to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < 32; r++)
                r_cnt[r] <= '0;
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (w_issue && (i_id_rd == 5'(r)))
                    r_cnt[r] <= w_load;
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - CW'(1);
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    // Per-register pending flags.
    always_comb begin
        o_busy = '0;
        for (int r = 1; r < 32; r++)
            o_busy[r] = (r_cnt[r] != '0);
    end

    assign o_forward_a    = w_fwd_a;
    assign o_forward_b    = w_fwd_b;
    assign o_stall        = w_stall;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, forwarding priority, x0 and
// unused operands, WAW, flush, mid-operation reset and latency clamping.
module tb_hazard_scoreboard;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_lat;
    logic        flush;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_rd;

    logic [1:0]  fa, fb, c_fa, c_fb;
    logic        stall, c_stall;
    logic [31:0] busy, c_busy, scyc, c_scyc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_FWD(2), .MAX_LAT(7)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_opcode(id_opcode),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd), .i_id_lat(id_lat),
        .i_flush(flush), .i_fwd_valid(fwd_valid), .i_fwd_rd(fwd_rd),
        .o_forward_a(fa), .o_forward_b(fb), .o_stall(stall),
        .o_busy(busy), .o_stall_cycles(scyc)
    );

    // Same stimulus, smaller latency cap, so that clamping is observable.
    hazard_scoreboard #(.NUM_FWD(2), .MAX_LAT(5)) u_dut_clamp (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_opcode(id_opcode),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd), .i_id_lat(id_lat),
        .i_flush(flush), .i_fwd_valid(fwd_valid), .i_fwd_rd(fwd_rd),
        .o_forward_a(c_fa), .o_forward_b(c_fb), .o_stall(c_stall),
        .o_busy(c_busy), .o_stall_cycles(c_scyc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] lat);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_lat    = lat;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fwd_valid = 2'b00;
        fwd_rd = '0;
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_busy",  busy, 32'h0);
        chk("rst_scyc",  scyc, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_fa",    {30'b0, fa}, 32'h0);
        chk("rst_fb",    {30'b0, fb}, 32'h0);

        // Load-use: load x5 lat 2, one bubble, then a consumer of x5.
        drv(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd5, 3'd2);
        chk("lu_issue_nostall", {31'b0, stall}, 32'h0);
        step();                                   // cnt5=2
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        chk("lu_busy5", busy, 32'h0000_0020);
        step();                                   // cnt5=1
        drv(1'b1, OP_R, 5'd5, 5'd6, 5'd8, 3'd1);
        chk("lu_stall1", {31'b0, stall}, 32'h1);
        step();                                   // cnt5=0, one stall counted
        chk("lu_stall0", {31'b0, stall}, 32'h0);
        chk("lu_busy0",  busy, 32'h0);
        step();                                   // consumer issues, cnt8=1
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        chk("lu_scyc",   scyc, 32'h1);
        chk("lu_busy8",  busy, 32'h0000_0100);
        step();                                   // cnt8=0

        // Forwarding priority.
        drv(1'b1, OP_R, 5'd5, 5'd5, 5'd0, 3'd0);
        fwd_valid = 2'b11;
        fwd_rd = {5'd5, 5'd5};
        #1;
        chk("fwd_both_a", {30'b0, fa}, 32'h1);
        chk("fwd_both_b", {30'b0, fb}, 32'h1);
        fwd_valid = 2'b10;
        #1;
        chk("fwd_src1_a", {30'b0, fa}, 32'h2);
        chk("fwd_src1_b", {30'b0, fb}, 32'h2);
        fwd_valid = 2'b11;
        fwd_rd = {5'd6, 5'd5};
        drv(1'b1, OP_R, 5'd5, 5'd6, 5'd0, 3'd0);
        chk("fwd_split_a", {30'b0, fa}, 32'h1);
        chk("fwd_split_b", {30'b0, fb}, 32'h2);

        // x0 and operands the opcode does not read.
        fwd_valid = 2'b01;
        fwd_rd = {5'd0, 5'd0};
        drv(1'b1, OP_R, 5'd0, 5'd9, 5'd0, 3'd0);
        chk("x0_fa", {30'b0, fa}, 32'h0);
        fwd_rd = {5'd0, 5'd5};
        drv(1'b1, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0);
        chk("lui_fa", {30'b0, fa}, 32'h0);
        drv(1'b1, OP_I, 5'd9, 5'd5, 5'd0, 3'd0);
        chk("itype_fb", {30'b0, fb}, 32'h0);
        drv(1'b1, OP_STORE, 5'd9, 5'd5, 5'd0, 3'd0);
        chk("store_fb", {30'b0, fb}, 32'h1);
        fwd_valid = 2'b00;
        fwd_rd = '0;

        // WAW: x7 pending 5, new writer with lat 2 waits until cnt7 <= 2.
        drv(1'b1, OP_I, 5'd0, 5'd0, 5'd7, 3'd5);
        step();                                   // cnt7=5
        drv(1'b1, OP_I, 5'd0, 5'd0, 5'd7, 3'd2);
        chk("waw_stall_c5", {31'b0, stall}, 32'h1);
        step();                                   // cnt7=4
        chk("waw_stall_c4", {31'b0, stall}, 32'h1);
        step();                                   // cnt7=3
        chk("waw_stall_c3", {31'b0, stall}, 32'h1);
        step();                                   // cnt7=2
        chk("waw_go_c2", {31'b0, stall}, 32'h0);
        step();                                   // issue, cnt7=2
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        chk("waw_busy_c2", busy, 32'h0000_0080);
        step();                                   // cnt7=1
        chk("waw_busy_c1", busy, 32'h0000_0080);
        step();                                   // cnt7=0
        chk("waw_busy_c0", busy, 32'h0);
        chk("waw_scyc", scyc, 32'h4);

        // Flush of a stalled instruction.
        drv(1'b1, OP_I, 5'd0, 5'd0, 5'd10, 3'd4);
        step();                                   // cnt10=4
        drv(1'b1, OP_I, 5'd0, 5'd0, 5'd11, 3'd6);
        step();                                   // cnt10=3 cnt11=6
        drv(1'b1, OP_R, 5'd10, 5'd0, 5'd12, 3'd5);
        chk("fl_stall_noflush", {31'b0, stall}, 32'h1);
        flush = 1'b1;
        #1;
        chk("fl_stall_flush", {31'b0, stall}, 32'h0);
        step();                                   // cnt10=2 cnt11=5, x12 untouched
        flush = 1'b0;
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        chk("fl_busy", busy, 32'h0000_0C00);
        step();
        step();                                   // cnt10=0 cnt11=3
        chk("fl_decr", busy, 32'h0000_0800);
        chk("fl_scyc", scyc, 32'h4);

        // Reset in the middle of operation.
        drv(1'b1, OP_I, 5'd0, 5'd0, 5'd3, 3'd4);
        step();                                   // cnt3=4 cnt11=2
        drv(1'b1, OP_R, 5'd3, 5'd11, 5'd0, 3'd0);
        chk("mr_stall_pre", {31'b0, stall}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mr_stall_forced0", {31'b0, stall}, 32'h0);
        step();
        rst = 1'b0;
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        chk("mr_busy", busy, 32'h0);
        chk("mr_scyc", scyc, 32'h0);

        // Latency cap: a 3-bit port sees 15 as 7; MAX_LAT=7 loads 7, MAX_LAT=5 loads 5.
        drv(1'b1, OP_I, 5'd0, 5'd0, 5'd4, 3'd7);
        step();                                   // main cnt4=7, clamp cnt4=5
        drv(1'b0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0);
        for (int i = 0; i < 4; i++) step();       // main 3, clamp 1
        chk("cl_main_k4",  busy, 32'h0000_0010);
        chk("cl_clamp_k4", c_busy, 32'h0000_0010);
        step();                                   // main 2, clamp 0
        chk("cl_main_k5",  busy, 32'h0000_0010);
        chk("cl_clamp_k5", c_busy, 32'h0);
        step();                                   // main 1
        chk("cl_main_k6",  busy, 32'h0000_0010);
        step();                                   // main 0
        chk("cl_main_k7",  busy, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
